// File: rtl/vga_timing_rx.sv
// vga_timing_rx: recovers lock, x/y and de from h_sync/v_sync alone; x/y/de trail the counters by one pixel tick, no backpressure.
// Define VGA_TIMING_RX_STATS_EN to add the err_count/frame_count statistics outputs.
module vga_timing_rx #(
    parameter int RESOLUTION_BITS = 10,
    parameter int AV_X            = 640,
    parameter int H_SYNC_PULSE    = 95,
    parameter int H_FRONT_PORCH   = 25,
    parameter int H_BACK_PORCH    = 40,
    parameter int AV_Y            = 480,
    parameter int V_SYNC_PULSE    = 2,
    parameter int V_FRONT_PORCH   = 10,
    parameter int V_BACK_PORCH    = 29,
    parameter int CNT_BITS        = 11,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       vga_clk,
    input  logic                       h_sync,
    input  logic                       v_sync,
    output logic [RESOLUTION_BITS-1:0] x,
    output logic [RESOLUTION_BITS-1:0] y,
    output logic                       de,
    output logic                       locked,
    output logic                       frame_start,
    output logic                       sync_err
`ifdef VGA_TIMING_RX_STATS_EN
    ,
    output logic [7:0]                 err_count,
    output logic [15:0]                frame_count
`endif
);

    localparam int H_TOTAL = AV_X + H_SYNC_PULSE + H_FRONT_PORCH + H_BACK_PORCH;
    localparam int V_TOTAL = AV_Y + V_SYNC_PULSE + V_FRONT_PORCH + V_BACK_PORCH;
    localparam int HA0     = H_SYNC_PULSE + H_BACK_PORCH;
    localparam int VA0     = V_SYNC_PULSE + V_BACK_PORCH;
    localparam int GW      = $clog2(LOCK_FRAMES + 1);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS:0]   H_TOT_W = (CNT_BITS+1)'(H_TOTAL);
    localparam logic [CNT_BITS:0]   V_TOT_W = (CNT_BITS+1)'(V_TOTAL);
    localparam logic [CNT_BITS-1:0] HA0_C   = CNT_BITS'(HA0);
    localparam logic [CNT_BITS-1:0] HAE_C   = CNT_BITS'(HA0 + AV_X);
    localparam logic [CNT_BITS-1:0] VA0_C   = CNT_BITS'(VA0);
    localparam logic [CNT_BITS-1:0] VAE_C   = CNT_BITS'(VA0 + AV_Y);
    localparam logic [GW-1:0]       LOCK_C  = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t                     state_q, state_d;
    logic                       hs_q, hs_d, vs_q, vs_d;
    logic [CNT_BITS-1:0]        h_cnt_q, h_cnt_d, l_cnt_q, l_cnt_d;
    logic                       line_err_q, line_err_d;
    logic [GW-1:0]              good_cnt_q, good_cnt_d;
    logic [RESOLUTION_BITS-1:0] x_q, x_d, y_q, y_d;
    logic                       de_q, de_d, locked_q, locked_d;
    logic                       frame_start_q, frame_start_d, sync_err_q, sync_err_d;

    logic hs_fall, vs_fall, h_sat, l_sat, line_bad, frame_good, in_win;

`ifdef VGA_TIMING_RX_STATS_EN
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [15:0] frm_cnt_q, frm_cnt_d;
`endif

    always_comb begin
        hs_fall    = hs_q & ~h_sync;
        vs_fall    = vs_q & ~v_sync;
        // A stuck counter is only an error when it would have advanced past its ceiling.
        h_sat      = ~hs_fall & (h_cnt_q == CNT_MAX);
        l_sat      = hs_fall & ~vs_fall & (l_cnt_q == CNT_MAX);
        line_bad   = hs_fall & (({1'b0, h_cnt_q} + (CNT_BITS+1)'(1)) != H_TOT_W);
        frame_good = (({1'b0, l_cnt_q} + {{CNT_BITS{1'b0}}, hs_fall}) == V_TOT_W) & ~line_err_q;
        in_win     = (h_cnt_q >= HA0_C) & (h_cnt_q < HAE_C) & (l_cnt_q >= VA0_C) & (l_cnt_q < VAE_C);

        state_d       = state_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        h_cnt_d       = h_cnt_q;
        l_cnt_d       = l_cnt_q;
        line_err_d    = line_err_q;
        good_cnt_d    = good_cnt_q;
        x_d           = x_q;
        y_d           = y_q;
        de_d          = de_q;
        locked_d      = locked_q;
        frame_start_d = 1'b0;
        sync_err_d    = 1'b0;

        if (vga_clk) begin
            hs_d    = h_sync;
            vs_d    = v_sync;
            h_cnt_d = hs_fall ? '0 : ((h_cnt_q == CNT_MAX) ? h_cnt_q : h_cnt_q + CNT_BITS'(1));

            if (vs_fall) begin
                l_cnt_d    = '0;
                line_err_d = 1'b0;
            end else begin
                if (hs_fall && l_cnt_q != CNT_MAX) l_cnt_d = l_cnt_q + CNT_BITS'(1);
                if (line_bad) line_err_d = 1'b1;
            end

            case (state_q)
                SEARCH: begin
                    if (vs_fall) begin
                        state_d    = TRACK;
                        good_cnt_d = '0;
                    end
                end
                TRACK: begin
                    if (h_sat | l_sat) begin
                        state_d = SEARCH;
                    end else if (vs_fall) begin
                        if (frame_good) begin
                            good_cnt_d = good_cnt_q + GW'(1);
                            if (good_cnt_q + GW'(1) == LOCK_C) state_d = LOCKED;
                        end else begin
                            good_cnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (line_bad | h_sat | l_sat | (vs_fall & ~frame_good)) begin
                        state_d    = SEARCH;
                        sync_err_d = 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase

            // Decode gates on the post-edge lock so de never outlives locked.
            locked_d      = (state_d == LOCKED);
            frame_start_d = vs_fall & locked_d;
            de_d          = locked_d & in_win;
            x_d           = de_d ? RESOLUTION_BITS'(h_cnt_q - HA0_C) : '0;
            y_d           = de_d ? RESOLUTION_BITS'(l_cnt_q - VA0_C) : '0;
        end

`ifdef VGA_TIMING_RX_STATS_EN
        err_cnt_d = (sync_err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        frm_cnt_d = frame_start_d ? frm_cnt_q + 16'd1 : frm_cnt_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= SEARCH;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            h_cnt_q       <= '0;
            l_cnt_q       <= '0;
            line_err_q    <= 1'b0;
            good_cnt_q    <= '0;
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= 1'b0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
`ifdef VGA_TIMING_RX_STATS_EN
            err_cnt_q     <= '0;
            frm_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            h_cnt_q       <= h_cnt_d;
            l_cnt_q       <= l_cnt_d;
            line_err_q    <= line_err_d;
            good_cnt_q    <= good_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            de_q          <= de_d;
            locked_q      <= locked_d;
            frame_start_q <= frame_start_d;
            sync_err_q    <= sync_err_d;
`ifdef VGA_TIMING_RX_STATS_EN
            err_cnt_q     <= err_cnt_d;
            frm_cnt_q     <= frm_cnt_d;
`endif
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign de          = de_q;
    assign locked      = locked_q;
    assign frame_start = frame_start_q;
    assign sync_err    = sync_err_q;
`ifdef VGA_TIMING_RX_STATS_EN
    assign err_count   = err_cnt_q;
    assign frame_count = frm_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx on a shrunken 25x11 raster; a timestamp-based model predicts every output on every clk.
module tb_vga_timing_rx;

    localparam int RB   = 10;
    localparam int AVX  = 16;
    localparam int HSP  = 4;
    localparam int HFP  = 2;
    localparam int HBP  = 3;
    localparam int AVY  = 6;
    localparam int VSP  = 2;
    localparam int VFP  = 1;
    localparam int VBP  = 2;
    localparam int CB   = 11;
    localparam int LF   = 2;
    localparam int HT   = AVX + HSP + HFP + HBP;
    localparam int VT   = AVY + VSP + VFP + VBP;
    localparam int HA0  = HSP + HBP;
    localparam int VA0  = VSP + VBP;
    localparam int CMAX = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          vga_clk = 1'b0;
    logic          h_sync = 1'b1;
    logic          v_sync = 1'b1;
    logic [RB-1:0] x, y;
    logic          de, locked, frame_start, sync_err;
`ifdef VGA_TIMING_RX_STATS_EN
    logic [7:0]    err_count;
    logic [15:0]   frame_count;
`endif

    vga_timing_rx #(
        .RESOLUTION_BITS(RB), .AV_X(AVX), .H_SYNC_PULSE(HSP), .H_FRONT_PORCH(HFP),
        .H_BACK_PORCH(HBP), .AV_Y(AVY), .V_SYNC_PULSE(VSP), .V_FRONT_PORCH(VFP),
        .V_BACK_PORCH(VBP), .CNT_BITS(CB), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .reset(reset), .vga_clk(vga_clk), .h_sync(h_sync), .v_sync(v_sync),
        .x(x), .y(y), .de(de), .locked(locked), .frame_start(frame_start), .sync_err(sync_err)
`ifdef VGA_TIMING_RX_STATS_EN
        ,
        .err_count(err_count), .frame_count(frame_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: line length from hs-fall timestamps, frame length in hs-falls,
    // lock as "seen a frame start and at least LF consecutive good frames since".
    int m_tick = 0;
    int last_hf, lines, run, n_err, n_fs;
    bit seen, frame_bad, prev_hs, prev_vs;
    bit ex_locked, ex_de, ex_fs, ex_se;
    int ex_x, ex_y;

    int tick_no = 0;
    int rst_at = -1;
    int se_seen, de_seen;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        seen = 0; run = 0; lines = 0; frame_bad = 0;
        prev_hs = 1; prev_vs = 1;
        last_hf = m_tick - 1;
        ex_locked = 0; ex_de = 0; ex_fs = 0; ex_se = 0; ex_x = 0; ex_y = 0;
    endtask

    task automatic model_tick(input bit hs, input bit vs);
        bit hf, vf, lbad, sat, fgood, loss;
        int hage, hq, lq;
        hf    = prev_hs && !hs;
        vf    = prev_vs && !vs;
        hage  = m_tick - last_hf - 1;
        hq    = (hage > CMAX) ? CMAX : hage;
        lq    = (lines > CMAX) ? CMAX : lines;
        lbad  = hf && (hage + 1 != HT);
        sat   = (!hf && hage >= CMAX) || (hf && !vf && lines >= CMAX);
        fgood = vf && (lines + int'(hf) == VT) && !frame_bad;
        loss  = 0;
        if (!seen) begin
            if (vf) begin seen = 1; run = 0; end
        end else if (!ex_locked) begin
            if (sat) begin seen = 0; run = 0; end
            else if (vf) run = fgood ? run + 1 : 0;
        end else if (lbad || sat || (vf && !fgood)) begin
            seen = 0; run = 0; loss = 1;
        end else if (vf) begin
            run++;
        end
        ex_locked = seen && (run >= LF);
        ex_se     = loss;
        ex_fs     = vf && ex_locked;
        ex_de     = ex_locked && hq >= HA0 && hq < HA0 + AVX && lq >= VA0 && lq < VA0 + AVY;
        ex_x      = ex_de ? hq - HA0 : 0;
        ex_y      = ex_de ? lq - VA0 : 0;
        if (loss && n_err < 255) n_err++;
        if (ex_fs) n_fs++;
        if (vf) begin
            lines = 0; frame_bad = 0;
        end else begin
            if (hf) lines++;
            if (lbad) frame_bad = 1;
        end
        if (hf) last_hf = m_tick;
        prev_hs = hs; prev_vs = vs;
        m_tick++;
    endtask

    task automatic compare_all();
        check("locked", locked, ex_locked);
        check("de", de, ex_de);
        check("x", x, ex_x);
        check("y", y, ex_y);
        check("frame_start", frame_start, ex_fs);
        check("sync_err", sync_err, ex_se);
    endtask

    task automatic cyc(input bit tick, input bit hs, input bit vs, input bit rst_n);
        @(negedge clk);
        vga_clk = tick; h_sync = hs; v_sync = vs; reset = rst_n;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            ex_fs = 0; ex_se = 0;
            if (tick) model_tick(hs, vs);
        end
        #1;
        compare_all();
        if (sync_err) se_seen++;
        if (de) de_seen++;
    endtask

    task automatic px(input bit hs, input bit vs);
        for (int i = 0; i < 3; i++) begin
            if (i == 1 && tick_no == rst_at) begin
                cyc(1'b0, hs, vs, 1'b0);
                check("rst_locked", locked, 0);
                check("rst_de", de, 0);
                check("rst_x", x, 0);
                check("rst_y", y, 0);
            end else begin
                cyc(1'b0, hs, vs, 1'b1);
            end
        end
        cyc(1'b1, hs, vs, 1'b1);
        tick_no++;
    endtask

    task automatic frame(input int nlines, input int bad_line, input int bad_len);
        int len;
        for (int l = 0; l < nlines; l++) begin
            len = (l == bad_line) ? bad_len : HT;
            for (int p = 0; p < len; p++) px(p < HSP ? 1'b0 : 1'b1, l < VSP ? 1'b0 : 1'b1);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, nl, bl, blen;
        n_err = 0; n_fs = 0;
        model_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);

        // Nominal stream: lock on the 3rd vs_fall, full active frame visible.
        frame(VT, -1, HT);
        frame(VT, -1, HT);
        check("pre_lock_locked", locked, 0);
        de_seen = 0;
        frame(VT, -1, HT);
        check("first_lock_locked", locked, 1);
        check("first_lock_de_clks", de_seen, AVX * AVY * 4);

        // One 24-tick line while locked, then relock.
        se_seen = 0;
        frame(VT, 5, HT - 1);
        check("short_line_sync_err", se_seen, 1);
        check("short_line_locked", locked, 0);
        frame(VT, -1, HT);
        frame(VT, -1, HT);
        check("short_relock_pending", locked, 0);
        frame(VT, -1, HT);
        check("short_relock", locked, 1);

        // h_sync stuck high while locked.
        se_seen = 0;
        for (int i = 0; i < 2100; i++) px(1'b1, 1'b1);
        check("sat_sync_err", se_seen, 1);
        check("sat_locked", locked, 0);
        check("sat_x", x, 0);
        check("sat_y", y, 0);

        // Short frame during TRACK resets the good-frame run.
        frame(VT, -1, HT);
        frame(VT - 1, -1, HT);
        frame(VT, -1, HT);
        frame(VT, -1, HT);
        check("track_short_frame_locked", locked, 0);
        frame(VT, -1, HT);
        check("track_relock", locked, 1);

        // Reset mid active line.
        rst_at = tick_no + 5 * HT + $urandom_range(HA0 + 2, HA0 + AVX - 1);
        frame(VT, -1, HT);
        check("after_rst_frame_locked", locked, 0);
        frame(VT, -1, HT);
        frame(VT, -1, HT);
        check("rst_relock_pending", locked, 0);
        frame(VT, -1, HT);
        check("rst_relock", locked, 1);

        // Randomised raster disturbances.
        for (int f = 0; f < 12; f++) begin
            r = $urandom_range(0, 5);
            nl = VT; bl = -1; blen = HT;
            if (r == 0) nl = ($urandom_range(0, 1) != 0) ? VT + 1 : VT - 1;
            else if (r == 1) begin
                bl = $urandom_range(1, VT - 1);
                blen = HT - 2 + $urandom_range(0, 4);
            end
            frame(nl, bl, blen);
        end
        frame(VT, -1, HT);

`ifdef VGA_TIMING_RX_STATS_EN
        check("err_count", err_count, n_err);
        check("frame_count", frame_count, n_fs % 65536);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
